// File: rtl/clk_div_multi.sv
// Lock-gated multi-channel clock divider: per-channel divided clocks and
// single-cycle enables from one fast clock, with glitch-free ratio updates
// and a calibration slip for word alignment.
module clk_div_multi #(
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned DIV_W         = 8,
  parameter int unsigned DEFAULT_DIV   = 5,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      lock_in,
  input  logic [NUM_CH*DIV_W-1:0]   div_ratio,
  input  logic                      load,
  input  logic                      calib,
  output logic [NUM_CH-1:0]         clk_out,
  output logic [NUM_CH-1:0]         ce_out,
  output logic                      ready
);

  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DEF_DIV  = DIV_W'(DEFAULT_DIV);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t            state, state_n;
  logic              sync1, sync2, lock_s;
  logic [SET_W-1:0]  settle_cnt, settle_cnt_n;

  logic [DIV_W-1:0]  cnt    [NUM_CH];
  logic [DIV_W-1:0]  cnt_n  [NUM_CH];
  logic [DIV_W-1:0]  act    [NUM_CH];
  logic [DIV_W-1:0]  act_n  [NUM_CH];
  logic [DIV_W-1:0]  shadow [NUM_CH];
  logic [NUM_CH-1:0] clk_n, ce_n;

  assign lock_s = sync2;

  // Two-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= lock_in;
      sync2 <= sync1;
    end
  end

  // Lock FSM next-state: any loss of lock returns to IDLE
  always_comb begin
    state_n      = state;
    settle_cnt_n = settle_cnt;
    if (!lock_s) begin
      state_n      = ST_IDLE;
      settle_cnt_n = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_n      = ST_SETTLE;
          settle_cnt_n = '0;
        end
        ST_SETTLE: begin
          if (settle_cnt == SET_LAST) state_n = ST_RUN;
          else settle_cnt_n = settle_cnt + SET_W'(1);
        end
        ST_RUN:  state_n = ST_RUN;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Lock FSM state register and ready flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      ready      <= 1'b0;
    end else begin
      state      <= state_n;
      settle_cnt <= settle_cnt_n;
      ready      <= (state_n == ST_RUN);
    end
  end

  // Per-channel counter / ratio next-state and next outputs
  always_comb begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      cnt_n[i] = cnt[i];
      act_n[i] = act[i];
      clk_n[i] = 1'b0;
      ce_n[i]  = 1'b0;
      if (state_n != ST_RUN || state != ST_RUN) begin
        // Not running, or first RUN cycle: phase-align at zero with fresh ratio
        cnt_n[i] = '0;
        act_n[i] = shadow[i];
      end else if (calib) begin
        // Frozen cycle: counter holds, level holds, enable suppressed
        clk_n[i] = clk_out[i];
      end else if (act[i] <= DIV_W'(1) || cnt[i] == act[i] - DIV_W'(1)) begin
        cnt_n[i] = '0;
        act_n[i] = shadow[i];
      end else begin
        cnt_n[i] = cnt[i] + DIV_W'(1);
      end
      if (state_n == ST_RUN && !(state == ST_RUN && calib)) begin
        // High while 2*cnt < div, i.e. cnt < (div+1)>>1, without overflow
        ce_n[i]  = (act_n[i] != '0) && (cnt_n[i] == '0);
        clk_n[i] = ({cnt_n[i], 1'b0} < {1'b0, act_n[i]});
      end
    end
  end

  // Per-channel registers: counters, ratios and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        cnt[i]    <= '0;
        act[i]    <= DEF_DIV;
        shadow[i] <= DEF_DIV;
      end
      clk_out <= '0;
      ce_out  <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        cnt[i] <= cnt_n[i];
        act[i] <= act_n[i];
        if (load) shadow[i] <= div_ratio[i*DIV_W +: DIV_W];
      end
      clk_out <= clk_n;
      ce_out  <= ce_n;
    end
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Randomised self-checking bench for clk_div_multi against a cycle-level
// reference model derived from the lock, divide and slip rules.
module tb_clk_div_multi;

  localparam int NUM_CH      = 2;
  localparam int DIV_W       = 8;
  localparam int DEFAULT_DIV = 5;
  localparam int SETTLE      = 16;

  logic                    clk, rst_n, lock_in, load, calib, ready;
  logic [NUM_CH*DIV_W-1:0] div_ratio;
  logic [NUM_CH-1:0]       clk_out, ce_out;

  int n_vec = 0;
  int n_err = 0;

  clk_div_multi #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .lock_in(lock_in), .div_ratio(div_ratio),
    .load(load), .calib(calib), .clk_out(clk_out), .ce_out(ce_out), .ready(ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference model: lock_in seen two edges late; RUN once SETTLE+1
  // consecutive synchronised-lock samples have been seen. Each channel is an
  // elapsed position within a period of length per; calib stretches a period.
  logic              m_d1, m_d2, m_was_run;
  int                m_run_len;
  int                m_pos    [NUM_CH];
  int                m_per    [NUM_CH];
  int                m_shadow [NUM_CH];
  logic              exp_ready;
  logic [NUM_CH-1:0] exp_clk, exp_ce;

  always @(posedge clk or negedge rst_n) begin : ref_model
    int pos, per, rl;
    bit ls, run, frozen;
    logic [NUM_CH-1:0] c, e;
    if (!rst_n) begin
      m_d1 <= 1'b0; m_d2 <= 1'b0; m_was_run <= 1'b0; m_run_len <= 0;
      exp_ready <= 1'b0; exp_clk <= '0; exp_ce <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        m_pos[ch] <= 0; m_per[ch] <= DEFAULT_DIV; m_shadow[ch] <= DEFAULT_DIV;
      end
    end else begin
      ls     = m_d2;
      rl     = ls ? ((m_run_len > SETTLE) ? m_run_len : m_run_len + 1) : 0;
      run    = (rl >= SETTLE + 1);
      frozen = run && m_was_run && calib;
      c = '0; e = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        pos = m_pos[ch];
        per = m_per[ch];
        if (!run || !m_was_run) begin
          pos = 0; per = m_shadow[ch];
        end else if (!calib) begin
          if (pos + 1 >= per) begin pos = 0; per = m_shadow[ch]; end
          else pos = pos + 1;
        end
        c[ch] = run && (per > 0) && (2 * pos < per);
        e[ch] = run && !frozen && (per > 0) && (pos == 0);
        m_pos[ch] <= pos;
        m_per[ch] <= per;
        if (load) m_shadow[ch] <= int'(div_ratio[ch*DIV_W +: DIV_W]);
      end
      m_d2 <= m_d1; m_d1 <= lock_in;
      m_run_len <= rl; m_was_run <= run;
      exp_ready <= run; exp_clk <= c; exp_ce <= e;
    end
  end

  task automatic set_ratio(input int r0, input int r1);
    div_ratio[0*DIV_W +: DIV_W] = DIV_W'(r0);
    div_ratio[1*DIV_W +: DIV_W] = DIV_W'(r1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; lock_in = 1'b0; load = 1'b0; calib = 1'b0; div_ratio = '0;
    repeat (3) begin
      @(negedge clk);
      n_vec++;
      if ({ready, clk_out, ce_out} !== 5'b0) begin
        n_err++;
        $display("FAIL reset_outputs: got rdy/clk/ce=%b, want 00000", {ready, clk_out, ce_out});
      end
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      n_vec++;
      if ({ready, clk_out, ce_out} !== {exp_ready, exp_clk, exp_ce}) begin
        n_err++;
        $display("FAIL reset_idle t=%0t: got %b/%b/%b want %b/%b/%b", $time,
                 ready, clk_out, ce_out, exp_ready, exp_clk, exp_ce);
      end
    end
  endtask

  task automatic test_lockup();
    int rise = -1;
    @(negedge clk);
    lock_in = 1'b1;
    for (int e = 1; e <= 40 && rise < 0; e++) begin
      @(negedge clk);
      n_vec++;
      if ({ready, clk_out, ce_out} !== {exp_ready, exp_clk, exp_ce}) begin
        n_err++;
        $display("FAIL lockup_model t=%0t: got %b/%b/%b want %b/%b/%b", $time,
                 ready, clk_out, ce_out, exp_ready, exp_clk, exp_ce);
      end
      if (ready === 1'b1) rise = e - 1;
    end
    n_vec++;
    if (rise != SETTLE + 2) begin
      n_err++;
      $display("FAIL lockup_latency: got %0d edges, want %0d", rise, SETTLE + 2);
    end
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      n_vec++;
      if (clk_out[0] !== ((i % 5) < 3) || ce_out[0] !== ((i % 5) == 0)) begin
        n_err++;
        $display("FAIL lockup_pattern i=%0d: got clk=%b ce=%b, want clk=%b ce=%b",
                 i, clk_out[0], ce_out[0], (i % 5) < 3, (i % 5) == 0);
      end
    end
  endtask

  task automatic test_ratios();
    int last [NUM_CH];
    int gap  [NUM_CH];
    for (int ch = 0; ch < NUM_CH; ch++) begin last[ch] = -1; gap[ch] = 0; end
    repeat ($urandom_range(1, 4)) @(negedge clk);
    set_ratio(4, 10);
    load = 1'b1;
    for (int t = 0; t < 45; t++) begin
      @(negedge clk);
      load = 1'b0;
      n_vec++;
      if ({ready, clk_out, ce_out} !== {exp_ready, exp_clk, exp_ce}) begin
        n_err++;
        $display("FAIL ratios_model t=%0t: got %b/%b/%b want %b/%b/%b", $time,
                 ready, clk_out, ce_out, exp_ready, exp_clk, exp_ce);
      end
      for (int ch = 0; ch < NUM_CH; ch++)
        if (ce_out[ch] === 1'b1) begin
          if (last[ch] >= 0) gap[ch] = t - last[ch];
          last[ch] = t;
        end
    end
    n_vec++;
    if (gap[0] != 4 || gap[1] != 10) begin
      n_err++;
      $display("FAIL ratios_period: got ch0=%0d ch1=%0d, want 4 and 10", gap[0], gap[1]);
    end
  endtask

  task automatic test_calib();
    int slips [2] = '{2, 4};
    set_ratio(5, 5);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (15) begin
      @(negedge clk);
      n_vec++;
      if ({ready, clk_out, ce_out} !== {exp_ready, exp_clk, exp_ce}) begin
        n_err++;
        $display("FAIL calib_model t=%0t: got %b/%b/%b want %b/%b/%b", $time,
                 ready, clk_out, ce_out, exp_ready, exp_clk, exp_ce);
      end
    end
    foreach (slips[k]) begin
      int found = 0;
      int gap = 0;
      int gap2 = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
        @(negedge clk);
        if (ce_out[0] === 1'b1) found = 1;
      end
      for (int g = 1; g <= 20 && gap == 0; g++) begin
        @(negedge clk);
        n_vec++;
        if ({ready, clk_out, ce_out} !== {exp_ready, exp_clk, exp_ce}) begin
          n_err++;
          $display("FAIL calib_slip_model t=%0t: got %b/%b/%b want %b/%b/%b", $time,
                   ready, clk_out, ce_out, exp_ready, exp_clk, exp_ce);
        end
        if (ce_out[0] === 1'b1) gap = g;
        calib = (g == slips[k]);
      end
      calib = 1'b0;
      for (int g = 1; g <= 20 && gap2 == 0; g++) begin
        @(negedge clk);
        if (ce_out[0] === 1'b1) gap2 = g;
      end
      n_vec++;
      if (found == 0 || gap != 6 || gap2 != 5) begin
        n_err++;
        $display("FAIL calib_gap slip_at=%0d: got gaps %0d,%0d, want 6,5", slips[k], gap, gap2);
      end
    end
  endtask

  task automatic test_lock_loss();
    int rise = -1;
    @(negedge clk);
    lock_in = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      if (e == 1) lock_in = 1'b1;
      n_vec++;
      if ({ready, clk_out, ce_out} !== {exp_ready, exp_clk, exp_ce}) begin
        n_err++;
        $display("FAIL lockloss_model t=%0t: got %b/%b/%b want %b/%b/%b", $time,
                 ready, clk_out, ce_out, exp_ready, exp_clk, exp_ce);
      end
    end
    n_vec++;
    if ({ready, clk_out, ce_out} !== 5'b0) begin
      n_err++;
      $display("FAIL lockloss_drop: got rdy/clk/ce=%b, want 00000", {ready, clk_out, ce_out});
    end
    for (int e = 4; e <= 45 && rise < 0; e++) begin
      @(negedge clk);
      n_vec++;
      if ({ready, clk_out, ce_out} !== {exp_ready, exp_clk, exp_ce}) begin
        n_err++;
        $display("FAIL lockloss_relock_model t=%0t: got %b/%b/%b want %b/%b/%b", $time,
                 ready, clk_out, ce_out, exp_ready, exp_clk, exp_ce);
      end
      if (ready === 1'b1) rise = e - 2;
    end
    n_vec++;
    if (rise != SETTLE + 2 || clk_out !== 2'b11 || ce_out !== 2'b11) begin
      n_err++;
      $display("FAIL lockloss_relock: got latency=%0d clk=%b ce=%b, want %0d 11 11",
               rise, clk_out, ce_out, SETTLE + 2);
    end
  endtask

  task automatic test_edge_ratios();
    set_ratio(1, 0);
    load = 1'b1;
    for (int t = 0; t < 15; t++) begin
      @(negedge clk);
      load = 1'b0;
      n_vec++;
      if ({ready, clk_out, ce_out} !== {exp_ready, exp_clk, exp_ce}) begin
        n_err++;
        $display("FAIL edge_model t=%0t: got %b/%b/%b want %b/%b/%b", $time,
                 ready, clk_out, ce_out, exp_ready, exp_clk, exp_ce);
      end
    end
    n_vec++;
    if (clk_out !== 2'b01 || ce_out !== 2'b01) begin
      n_err++;
      $display("FAIL edge_div1_div0: got clk=%b ce=%b, want 01 01", clk_out, ce_out);
    end
    set_ratio(1, 3);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_vec++;
      if (clk_out !== {((i % 3) < 2), 1'b1} || ce_out !== {((i % 3) == 0), 1'b1}) begin
        n_err++;
        $display("FAIL edge_ch1_start i=%0d: got clk=%b ce=%b, want clk=%b ce=%b", i,
                 clk_out, ce_out, {((i % 3) < 2), 1'b1}, {((i % 3) == 0), 1'b1});
      end
    end
  endtask

  task automatic test_async_reset();
    int found = 0;
    int gap = 0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({ready, clk_out, ce_out} !== 5'b0 || {exp_ready, exp_clk, exp_ce} !== 5'b0) begin
      n_err++;
      $display("FAIL async_reset: got rdy/clk/ce=%b, want 00000", {ready, clk_out, ce_out});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e < 45 && found == 0; e++) begin
      @(negedge clk);
      n_vec++;
      if ({ready, clk_out, ce_out} !== {exp_ready, exp_clk, exp_ce}) begin
        n_err++;
        $display("FAIL async_reset_model t=%0t: got %b/%b/%b want %b/%b/%b", $time,
                 ready, clk_out, ce_out, exp_ready, exp_clk, exp_ce);
      end
      if (ready === 1'b1) found = 1;
    end
    for (int g = 1; g <= 12 && gap == 0; g++) begin
      @(negedge clk);
      if (ce_out[0] === 1'b1) gap = g;
    end
    n_vec++;
    if (found == 0 || gap != DEFAULT_DIV) begin
      n_err++;
      $display("FAIL async_reset_default_div: got ready=%0d period=%0d, want 1 and %0d",
               found, gap, DEFAULT_DIV);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      n_vec++;
      if ({ready, clk_out, ce_out} !== {exp_ready, exp_clk, exp_ce}) begin
        n_err++;
        $display("FAIL random_model t=%0t: got %b/%b/%b want %b/%b/%b", $time,
                 ready, clk_out, ce_out, exp_ready, exp_clk, exp_ce);
      end
      lock_in = ($urandom_range(0, 79) != 0);
      calib   = ($urandom_range(0, 11) == 0);
      load    = ($urandom_range(0, 7) == 0);
      if (load)
        for (int ch = 0; ch < NUM_CH; ch++)
          div_ratio[ch*DIV_W +: DIV_W] = ($urandom_range(0, 15) == 0) ?
              DIV_W'($urandom_range(200, 255)) : DIV_W'($urandom_range(0, 12));
    end
    lock_in = 1'b1; load = 1'b0; calib = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lockup();
    test_ratios();
    test_calib();
    test_lock_loss();
    test_edge_ratios();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
